div_iter_core: RTL
==================

Name: div_iter_core

Overview:
- Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits directly upstream of the divide output sign-correction stage.
- Takes raw operands and forms magnitudes on signed ops, then iterates one bit per clock.
- Presents an unsigned quotient/remainder plus operand sign flags; the downstream stage applies the final negation and quotient/remainder selection.

Parameters:
XLEN, 32, operand/result width
CNT_W, 5, iteration counter width; must equal clog2(XLEN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept request (high only in IDLE)
dividend  input  XLEN  rs1 value
divisor  input  XLEN  rs2 value
op_div  input  2  [0]=1 unsigned, [1]=1 remainder requested; passed through
out_valid  output  1  result valid, held until out_ready
out_ready  input  1  downstream consumes result
Q  output  XLEN  unsigned quotient magnitude
R  output  XLEN  unsigned remainder magnitude
Dividend32  output  1  dividend sign (0 for unsigned ops)
Divisor32  output  1  divisor sign (0 for unsigned ops)
Divisor_2C  output  XLEN  two's complement of the captured raw divisor (~divisor+1)
op_div_out  output  2  op_div captured at acceptance

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; Q, R, Divisor_2C, counter=0; Dividend32, Divisor32=0; op_div_out=0. An in-flight operation is discarded and no result is produced.
- FSM states: IDLE, CALC, DONE. in_ready = (state==IDLE).
- IDLE: on the edge with in_valid&in_ready, capture:
  - op_div into op_div_out.
  - Sign flags = operand[XLEN-1] & ~op_div[0].
  - Magnitudes: |x| when the sign flag is set, else x. 0x80000000 stays 0x80000000 as unsigned.
  - Divisor_2C = ~divisor+1.
  - Rem accumulator cleared; quotient shift register loaded with |dividend|; counter=0.
  - Next state is CALC.
- CALC: one iteration per edge.
  - {rem,quo} shifted left by 1; trial = rem_shifted - |divisor| at XLEN+1 bits.
  - If trial is non-negative, rem=trial and quo[0]=1; else rem keeps the shifted value and quo[0]=0.
  - counter++. On the edge where counter==XLEN-1, latch Q/R and go to DONE.
- Latency: out_valid is high starting 32 clocks after the accepting edge.
- DONE: out_valid=1; all outputs are stable while out_ready=0. On the edge with out_ready=1, go to IDLE and clear out_valid. No new request is accepted in the same edge.
- Divide by zero (|divisor|==0) runs the normal 32 iterations. The result is then overridden:
  - R = |dividend|.
  - Q = 0xFFFFFFFF, except when Dividend32=1, where Q = 0x00000001.
  - After downstream negation this yields quotient = -1 and remainder = dividend per the ISA.
- Signed overflow (0x80000000 / 0xFFFFFFFF): no special case. Natural result Q=0x80000000, R=0 with both sign flags set gives the ISA result downstream.
- in_valid outside IDLE is ignored and operands are not sampled.
- Operand inputs are sampled only at acceptance; later changes have no effect.

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN.
- Defined: when the divisor magnitude is 0 at acceptance, go IDLE -> DONE directly with the override values; out_valid is high 1 clock after the accepting edge.
- Undefined: a zero divisor takes the full 32-iteration path with the same final values.
- Non-zero divisors behave identically either way.

Decomposition:
- Shared muldiv package holds:
  - XLEN.
  - State enum {IDLE, CALC, DONE}.
  - op_div bit-index constants OP_UNSIGNED=0, OP_REM=1.
  - Constant DIV_ZERO_Q = all ones.
- One sub-module, div_abs_sel: conditional two's-complement magnitude, instantiated twice, once per operand.
- FSM and datapath stay in div_iter_core.

Test Plan:
1. 100/7 unsigned (op_div=01) -> after 32 clks Q=14, R=2, signs 0, op_div_out=01.
2. -7/2 signed (op_div=00) -> Q=3, R=1, Dividend32=1, Divisor32=0, Divisor_2C=0xFFFFFFFE.
3. Divide by zero, signed: -5/0 -> Q=1, R=5, Dividend32=1. Same with 5/0 -> Q=0xFFFFFFFF, R=5. Check latency with and without DIV_ZERO_BYPASS_EN (1 vs 32 clks).
4. 0x80000000/0xFFFFFFFF signed -> Q=0x80000000, R=0, both sign flags 1. Same operands unsigned -> Q=0, R=0x80000000.
5. Backpressure: hold out_ready=0 for 10 clks -> outputs stable, in_ready=0, a new in_valid is ignored. The out_ready pulse returns to IDLE and in_ready=1 on the next clock.
6. Assert rst asynchronously at iteration 10 -> out_valid=0 and in_ready=1 immediately. A fresh request afterwards gives a correct result with 32-clk latency.

Source files
------------

// File: rtl/div_iter_core_pkg.sv
// Shared muldiv definitions: operand width, divider FSM states, op_div bit
// positions and the divide-by-zero quotient constant.
package div_iter_core_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int unsigned OP_UNSIGNED = 0;
  localparam int unsigned OP_REM      = 1;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_abs_sel.sv
// Conditional two's-complement magnitude: passes the operand through, or
// negates it when neg_i is set. 0x80000000 negates to itself.
module div_abs_sel #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] val_i,
  input  logic            neg_i,
  output logic [XLEN-1:0] mag_c_o
);

  assign mag_c_o = neg_i ? (~val_i + XLEN'(1)) : val_i;

endmodule

// File: rtl/div_iter_core.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU producing unsigned Q/R
// magnitudes and operand sign flags. DIV_ZERO_BYPASS_EN short-circuits /0.
module div_iter_core #(
  parameter int unsigned XLEN  = div_iter_core_pkg::XLEN,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic [1:0]      op_div,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Q,
  output logic [XLEN-1:0] R,
  output logic            Dividend32,
  output logic            Divisor32,
  output logic [XLEN-1:0] Divisor_2C,
  output logic [1:0]      op_div_out
);

  import div_iter_core_pkg::*;

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  rem_q, quo_q, dvs_mag_q;
  logic [XLEN-1:0]  q_res_q, r_res_q, d2c_q;
  logic             dvd_sgn_q, dvs_sgn_q;
  logic [1:0]       op_q;
  logic             out_valid_q, in_ready_q;

  logic             dvd_sgn_c, dvs_sgn_c;
  logic [XLEN-1:0]  dvd_mag_c, dvs_mag_c;
  logic [XLEN:0]    rem_sh_c, trial_c;
  logic [XLEN-1:0]  rem_d, quo_d, q_fin_c, q_zero_c;

  assign dvd_sgn_c = dividend[XLEN-1] & ~op_div[OP_UNSIGNED];
  assign dvs_sgn_c = divisor[XLEN-1]  & ~op_div[OP_UNSIGNED];

  div_abs_sel #(.XLEN(XLEN)) u_abs_dvd (
    .val_i   (dividend),
    .neg_i   (dvd_sgn_c),
    .mag_c_o (dvd_mag_c)
  );

  div_abs_sel #(.XLEN(XLEN)) u_abs_dvs (
    .val_i   (divisor),
    .neg_i   (dvs_sgn_c),
    .mag_c_o (dvs_mag_c)
  );

  // One restoring step; the /0 quotient becomes 1 for a negative dividend so
  // that the downstream negation yields -1.
  always_comb begin
    rem_sh_c = {rem_q, quo_q[XLEN-1]};
    trial_c  = rem_sh_c - {1'b0, dvs_mag_q};
    quo_d    = {quo_q[XLEN-2:0], ~trial_c[XLEN]};
    rem_d    = trial_c[XLEN] ? rem_sh_c[XLEN-1:0] : trial_c[XLEN-1:0];
    q_zero_c = dvd_sgn_c ? XLEN'(1) : XLEN'(DIV_ZERO_Q);
    q_fin_c  = quo_d;
    if ((dvs_mag_q == '0) && dvd_sgn_q) begin
      q_fin_c = XLEN'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_mag_q   <= '0;
      q_res_q     <= '0;
      r_res_q     <= '0;
      d2c_q       <= '0;
      dvd_sgn_q   <= 1'b0;
      dvs_sgn_q   <= 1'b0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q       <= op_div;
            dvd_sgn_q  <= dvd_sgn_c;
            dvs_sgn_q  <= dvs_sgn_c;
            d2c_q      <= ~divisor + XLEN'(1);
            rem_q      <= '0;
            quo_q      <= dvd_mag_c;
            dvs_mag_q  <= dvs_mag_c;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
            if (dvs_mag_c == '0) begin
              q_res_q     <= q_zero_c;
              r_res_q     <= dvd_mag_c;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= CALC;
            end
`else
            state_q <= CALC;
`endif
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            q_res_q     <= q_fin_c;
            r_res_q     <= rem_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign Q          = q_res_q;
  assign R          = r_res_q;
  assign Dividend32 = dvd_sgn_q;
  assign Divisor32  = dvs_sgn_q;
  assign Divisor_2C = d2c_q;
  assign op_div_out = op_q;

endmodule
